// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment page selector.
package seg_pkg;

  typedef logic [1:0] seg_mode_t;

  localparam seg_mode_t SEG_MODE_OFF    = 2'd0;
  localparam seg_mode_t SEG_MODE_STATIC = 2'd1;
  localparam seg_mode_t SEG_MODE_BLINK  = 2'd2;
  localparam seg_mode_t SEG_MODE_SCROLL = 2'd3;

  localparam logic [7:0] SEG_BLANK = 8'h00;

  // Bit offset of digit `digit` of page `page` in the flat page_data vector.
  function automatic int seg_flat_idx(input int page, input int digit,
                                      input int digits, input int segw);
    return (page * digits + digit) * segw;
  endfunction

endpackage

// File: rtl/seg_page_mux_if.sv
// Select/mode strobe, pacing tick, page inputs and display outputs of seg_page_mux.
interface seg_page_mux_if #(
  parameter int unsigned DIGITS = 8,
  parameter int unsigned PAGES  = 16,
  parameter int unsigned SEGW   = 8,
  parameter int unsigned PW     = $clog2(PAGES + 1)
);
  logic [PAGES*DIGITS*SEGW-1:0] page_data;
  logic [PW-1:0]                select;
  logic [1:0]                   mode;
  logic                         select_valid;
  logic                         tick;
  logic [DIGITS*SEGW-1:0]       seg_out;
  logic [PW-1:0]                page_cur;
  logic                         wrap;

  modport master (
    output page_data, select, mode, select_valid, tick,
    input  seg_out, page_cur, wrap
  );

  modport slave (
    input  page_data, select, mode, select_valid, tick,
    output seg_out, page_cur, wrap
  );
endinterface

// File: rtl/seg_tick_div.sv
// Tick-qualified modulo-DIV counter; tc_o pulses on the tick that wraps it to 0.
module seg_tick_div #(
  parameter int unsigned DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick_i,
  input  logic clr_i,
  output logic tc_o
);
  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] Last = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tc_o  = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == Last) begin
        cnt_d = '0;
        tc_o  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_page_mux.sv
// Registered page selector for the seven-segment display with static, blink and scroll modes.
module seg_page_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS     = 8,
  parameter int unsigned PAGES      = 16,
  parameter int unsigned SEGW       = 8,
  parameter int unsigned BLINK_DIV  = 4,
  parameter int unsigned SCROLL_DIV = 2,
  parameter int unsigned PW         = $clog2(PAGES + 1)
) (
  input logic            clk,
  input logic            rst,
  seg_page_mux_if.slave  bus_io
);
  localparam int unsigned VLEN = 2 * DIGITS;
  localparam int unsigned OW   = $clog2(VLEN);
  localparam logic [OW-1:0] OffLast = OW'(VLEN - 1);

  logic [PW-1:0]          page_q, page_d;
  seg_mode_t              mode_q, mode_d;
  logic                   vis_q, vis_d;
  logic [OW-1:0]          off_q, off_d;
  logic                   wrap_q, wrap_d;
  logic [DIGITS*SEGW-1:0] seg_q, seg_d;

  logic tick_ok, blink_clr, scroll_clr, blink_tc, scroll_tc;

  // A select in the same cycle as a tick discards the tick.
  assign tick_ok    = bus_io.tick & ~bus_io.select_valid;
  assign blink_clr  = bus_io.select_valid | (mode_q != SEG_MODE_BLINK);
  assign scroll_clr = bus_io.select_valid | (mode_q != SEG_MODE_SCROLL);

  seg_tick_div #(.DIV(BLINK_DIV)) u_blink_div (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick_ok),
    .clr_i  (blink_clr),
    .tc_o   (blink_tc)
  );

  seg_tick_div #(.DIV(SCROLL_DIV)) u_scroll_div (
    .clk    (clk),
    .rst    (rst),
    .tick_i (tick_ok),
    .clr_i  (scroll_clr),
    .tc_o   (scroll_tc)
  );

  always_comb begin
    page_d = page_q;
    mode_d = mode_q;
    vis_d  = vis_q;
    off_d  = off_q;
    wrap_d = 1'b0;
    if (bus_io.select_valid) begin
      page_d = bus_io.select;
      mode_d = bus_io.mode;
      vis_d  = 1'b1;
      off_d  = '0;
    end else begin
      if (blink_tc) vis_d = ~vis_q;
      if (scroll_tc) begin
        if (off_q == OffLast) begin
          off_d  = '0;
          wrap_d = 1'b1;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
    end
  end

  // Output pattern is built from next-state so a change shows one cycle later.
  always_comb begin
    int idx;
    seg_d = '0;
    idx   = 0;
    if (int'(page_d) < PAGES) begin
      unique case (mode_d)
        SEG_MODE_STATIC, SEG_MODE_BLINK: begin
          if (mode_d == SEG_MODE_STATIC || vis_d) begin
            for (int d = 0; d < DIGITS; d++) begin
              seg_d[d*SEGW +: SEGW] =
                bus_io.page_data[seg_flat_idx(int'(page_d), d, DIGITS, SEGW) +: SEGW];
            end
          end
        end
        SEG_MODE_SCROLL: begin
          for (int d = 0; d < DIGITS; d++) begin
            idx = d + int'(off_d);
            if (idx >= VLEN) idx = idx - VLEN;
            if (idx < DIGITS) begin
              seg_d[d*SEGW +: SEGW] =
                bus_io.page_data[seg_flat_idx(int'(page_d), idx, DIGITS, SEGW) +: SEGW];
            end
          end
        end
        default: seg_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      page_q <= '0;
      mode_q <= SEG_MODE_OFF;
      vis_q  <= 1'b1;
      off_q  <= '0;
      wrap_q <= 1'b0;
      seg_q  <= '0;
    end else begin
      page_q <= page_d;
      mode_q <= mode_d;
      vis_q  <= vis_d;
      off_q  <= off_d;
      wrap_q <= wrap_d;
      seg_q  <= seg_d;
    end
  end

  assign bus_io.seg_out  = seg_q;
  assign bus_io.page_cur = page_q;
  assign bus_io.wrap     = wrap_q;

endmodule

// File: tb/tb_seg_page_mux.sv
// Directed, table-driven bench for seg_page_mux with hand sequences for scroll and reset.
module tb_seg_page_mux;
  import seg_pkg::*;

  localparam int unsigned DIGITS     = 8;
  localparam int unsigned PAGES      = 4;
  localparam int unsigned SEGW       = 8;
  localparam int unsigned BLINK_DIV  = 4;
  localparam int unsigned SCROLL_DIV = 2;
  localparam int unsigned PW         = $clog2(PAGES + 1);
  localparam int unsigned SW         = DIGITS * SEGW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seg_page_mux_if #(.DIGITS(DIGITS), .PAGES(PAGES), .SEGW(SEGW), .PW(PW)) bus ();

  seg_page_mux #(
    .DIGITS     (DIGITS),
    .PAGES      (PAGES),
    .SEGW       (SEGW),
    .BLINK_DIV  (BLINK_DIV),
    .SCROLL_DIV (SCROLL_DIV),
    .PW         (PW)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus.slave)
  );

  logic [SEGW-1:0] pd [PAGES][DIGITS];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    string         name;
    logic [PW-1:0] sel;
    logic [1:0]    mode;
    logic          valid;
    logic          tick;
    logic [SW-1:0] seg;
    logic [PW-1:0] page;
    logic          wrap;
  } vec_t;
  vec_t vt[$];

  // Expected display for page p viewed at scroll offset off (off=0 is the plain page).
  function automatic logic [SW-1:0] exp_view(input int p, input int off);
    logic [SW-1:0] r;
    r = '0;
    if (p < PAGES) begin
      for (int d = 0; d < DIGITS; d++) begin
        int i;
        i = (d + off) % (2 * DIGITS);
        if (i < DIGITS) r[d*SEGW +: SEGW] = pd[p][i];
      end
    end
    return r;
  endfunction

  task automatic pack();
    for (int p = 0; p < PAGES; p++)
      for (int d = 0; d < DIGITS; d++)
        bus.page_data[(p*DIGITS+d)*SEGW +: SEGW] = pd[p][d];
  endtask

  task automatic drive(input logic [PW-1:0] sel, input logic [1:0] mode,
                       input logic valid, input logic tick);
    bus.select       = sel;
    bus.mode         = mode;
    bus.select_valid = valid;
    bus.tick         = tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [SW-1:0] seg,
                       input logic [PW-1:0] page, input logic wrap);
    n_cmp++;
    if (bus.seg_out !== seg) begin
      n_bad++;
      $display("FAIL %s seg_out: got %h want %h", name, bus.seg_out, seg);
    end
    n_cmp++;
    if (bus.page_cur !== page) begin
      n_bad++;
      $display("FAIL %s page_cur: got %0d want %0d", name, bus.page_cur, page);
    end
    n_cmp++;
    if (bus.wrap !== wrap) begin
      n_bad++;
      $display("FAIL %s wrap: got %b want %b", name, bus.wrap, wrap);
    end
  endtask

  task automatic add(input string name, input logic [PW-1:0] sel, input logic [1:0] mode,
                     input logic valid, input logic tick, input logic [SW-1:0] seg,
                     input logic [PW-1:0] page);
    vec_t v;
    v.name = name; v.sel = sel; v.mode = mode; v.valid = valid; v.tick = tick;
    v.seg = seg; v.page = page; v.wrap = 1'b0;
    vt.push_back(v);
  endtask

  initial begin
    int wraps;
    for (int p = 0; p < PAGES; p++)
      for (int d = 0; d < DIGITS; d++)
        pd[p][d] = SEGW'(p * 16 + d + 1);
    pack();
    bus.select = '0; bus.mode = SEG_MODE_OFF; bus.select_valid = 1'b0; bus.tick = 1'b0;

    rst = 1'b1;
    drive('0, SEG_MODE_OFF, 1'b0, 1'b0);
    drive('0, SEG_MODE_OFF, 1'b0, 1'b0);
    check("reset", '0, '0, 1'b0);
    rst = 1'b0;
    drive('0, SEG_MODE_OFF, 1'b0, 1'b1);
    check("off_tick", '0, '0, 1'b0);

    add("static_sel3",  3, SEG_MODE_STATIC, 1, 0, exp_view(3, 0), 3);
    add("static_tick",  0, SEG_MODE_OFF,    0, 1, exp_view(3, 0), 3);
    add("oor_static",   4, SEG_MODE_STATIC, 1, 0, '0, 4);
    add("oor_blink",    4, SEG_MODE_BLINK,  1, 0, '0, 4);
    add("off_sel1",     1, SEG_MODE_OFF,    1, 0, '0, 1);
    add("blink_sel2",   2, SEG_MODE_BLINK,  1, 0, exp_view(2, 0), 2);
    add("blink_t1",     0, SEG_MODE_OFF,    0, 1, exp_view(2, 0), 2);
    add("blink_t2",     0, SEG_MODE_OFF,    0, 1, exp_view(2, 0), 2);
    add("blink_idle",   0, SEG_MODE_OFF,    0, 0, exp_view(2, 0), 2);
    add("blink_t3",     0, SEG_MODE_OFF,    0, 1, exp_view(2, 0), 2);
    add("blink_t4",     0, SEG_MODE_OFF,    0, 1, '0, 2);
    add("blink_t5",     0, SEG_MODE_OFF,    0, 1, '0, 2);
    add("blink_t6",     0, SEG_MODE_OFF,    0, 1, '0, 2);
    add("blink_t7",     0, SEG_MODE_OFF,    0, 1, '0, 2);
    add("blink_t8",     0, SEG_MODE_OFF,    0, 1, exp_view(2, 0), 2);
    add("blink_t9",     0, SEG_MODE_OFF,    0, 1, exp_view(2, 0), 2);
    add("blink_resel",  2, SEG_MODE_BLINK,  1, 0, exp_view(2, 0), 2);
    add("to_static",    2, SEG_MODE_STATIC, 1, 1, exp_view(2, 0), 2);
    foreach (vt[i]) begin
      drive(vt[i].sel, vt[i].mode, vt[i].valid, vt[i].tick);
      check(vt[i].name, vt[i].seg, vt[i].page, vt[i].wrap);
    end

    // Full scroll revolution: 16 steps of SCROLL_DIV ticks, one wrap pulse.
    drive(0, SEG_MODE_SCROLL, 1'b1, 1'b0);
    check("scroll_sel0", exp_view(0, 0), 0, 1'b0);
    wraps = 0;
    for (int k = 1; k <= 32; k++) begin
      drive(0, SEG_MODE_SCROLL, 1'b0, 1'b1);
      if (bus.wrap === 1'b1) wraps++;
      check($sformatf("scroll_k%0d", k), exp_view(0, (k / 2) % 16), 0, k == 32);
    end
    drive(0, SEG_MODE_SCROLL, 1'b0, 1'b0);
    check("scroll_after_wrap", exp_view(0, 0), 0, 1'b0);
    n_cmp++;
    if (wraps != 1) begin
      n_bad++;
      $display("FAIL scroll_wrap_count: got %0d want 1", wraps);
    end

    // Select and tick together at offset 5: select wins, divider restarts.
    for (int k = 0; k < 10; k++) drive(0, SEG_MODE_SCROLL, 1'b0, 1'b1);
    check("scroll_off5", exp_view(0, 5), 0, 1'b0);
    drive(0, SEG_MODE_SCROLL, 1'b1, 1'b1);
    check("sel_tick_same", exp_view(0, 0), 0, 1'b0);
    drive(0, SEG_MODE_SCROLL, 1'b0, 1'b1);
    check("sel_tick_t1", exp_view(0, 0), 0, 1'b0);
    drive(0, SEG_MODE_SCROLL, 1'b0, 1'b1);
    check("sel_tick_t2", exp_view(0, 1), 0, 1'b0);

    // Live page_data update with no re-select.
    drive(3, SEG_MODE_STATIC, 1'b1, 1'b0);
    check("live_before", exp_view(3, 0), 3, 1'b0);
    pd[3][0] = 8'hA5;
    pd[3][7] = 8'h5A;
    pack();
    drive(3, SEG_MODE_STATIC, 1'b0, 1'b0);
    check("live_after", exp_view(3, 0), 3, 1'b0);

    // Reset mid-scroll at offset 9.
    drive(1, SEG_MODE_SCROLL, 1'b1, 1'b0);
    for (int k = 0; k < 18; k++) drive(1, SEG_MODE_SCROLL, 1'b0, 1'b1);
    check("pre_rst_off9", exp_view(1, 9), 1, 1'b0);
    rst = 1'b1;
    drive(1, SEG_MODE_SCROLL, 1'b0, 1'b1);
    check("mid_rst", '0, '0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      drive(1, SEG_MODE_SCROLL, 1'b0, 1'b1);
      check($sformatf("post_rst_t%0d", k), '0, '0, 1'b0);
    end
    drive(0, SEG_MODE_SCROLL, 1'b1, 1'b0);
    check("post_rst_scroll", exp_view(0, 0), 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
